// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the memory stage and the data-memory controller.
// The pipeline side uses the master modport, and the controller uses the slave modport.
interface dmem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] valM;
  logic        stall;
  logic        dmem_error;

  modport master (
    output mem_read, mem_write, mem_addr, mem_data,
    input  valM, stall, dmem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_data,
    output valM, stall, dmem_error
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: serves 32-bit little-endian word accesses to a byte-wide RAM,
// one byte per clock. Define DMEM_ALIGN_CHECK_EN to reject word addresses that are not 4-byte aligned.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           rbuf;
  logic [31:0]           valm_q;
  logic                  err_q;

  logic                  req;
  logic                  bad_req;
  logic                  range_bad;
  logic                  wrap_bad;
  logic                  align_bad;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [7:0]            rd_byte;
  logic [7:0]            wr_byte;

  logic [7:0] ram [2**ADDR_WIDTH];

  // Request decode. The wrap test is "low address > 2^AW - 4".
  // That means all bits above bit 1 are set and the byte offset is nonzero.
  assign req       = bus.mem_read | bus.mem_write;
  assign range_bad = |bus.mem_addr[31:ADDR_WIDTH];
  assign wrap_bad  = (&bus.mem_addr[ADDR_WIDTH-1:2]) & (|bus.mem_addr[1:0]);
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_bad = |bus.mem_addr[1:0];
`else
  assign align_bad = 1'b0;
`endif
  assign bad_req   = (bus.mem_read & bus.mem_write) | range_bad | wrap_bad | align_bad;

  // Byte lane for the current transfer beat. The address cannot wrap, because
  // requests that would wrap are rejected in IDLE.
  assign byte_addr = addr_q + ADDR_WIDTH'(cnt);
  assign rd_byte   = ram[byte_addr];
  assign wr_byte   = data_q[{cnt, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case statement,
    // so that no path leaves a signal unassigned and infers a latch.
    state_nxt = state;
    bus.stall = 1'b0;
    unique case (state)
      IDLE: begin
        bus.stall = req;
        if (req) state_nxt = bad_req ? DONE : XFER;
      end
      XFER: begin
        bus.stall = 1'b1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values no matter what order the statements run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rbuf     <= '0;
      valm_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) & req & bad_req;
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (req && !bad_req) begin
            op_write <= bus.mem_write;
            addr_q   <= bus.mem_addr[ADDR_WIDTH-1:0];
            data_q   <= bus.mem_data;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (!op_write) begin
            rbuf[{cnt, 3'b000} +: 8] <= rd_byte;
            if (cnt == 2'd3) valm_q <= {rd_byte, rbuf[23:0]};
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  // NOTE: the RAM has no reset. Its contents survive rst. A reset in the middle of a
  // transfer stops the writes, because state is forced to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (state == XFER && op_write) ram[byte_addr] <= wr_byte;
  end

  assign bus.valM       = valm_q;
  assign bus.dmem_error = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with ADDR_WIDTH=12.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] valm_model;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE, hold it until stall drops, and sample the DONE cycle.
  // When keep is set, the request stays asserted through DONE.
  // The task returns one cycle after DONE, in IDLE.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic exp_err, input logic [31:0] exp_rdata, input bit keep);
    int          n;
    bit          early_err;
    logic [31:0] v_before;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_data  = data;
    #1;
    n         = 0;
    early_err = 1'b0;
    v_before  = bus.valM;
    while (bus.stall === 1'b1 && n < 20) begin
      if (bus.dmem_error !== 1'b0) early_err = 1'b1;
      v_before = bus.valM;
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, n, exp_err ? 32'd1 : 32'd5);
    check({tag, " err_before_done"}, {31'd0, early_err}, 32'd0);
    check({tag, " valM_before_done"}, v_before, valm_model);
    check({tag, " dmem_error_done"}, {31'd0, bus.dmem_error}, {31'd0, exp_err});
    if (rd && !wr && !exp_err) valm_model = exp_rdata;
    check({tag, " valM_done"}, bus.valM, valm_model);
    if (!keep) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, " dmem_error_after"}, {31'd0, bus.dmem_error}, 32'd0);
    check({tag, " valM_held"}, bus.valM, valm_model);
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    valm_model    = '0;
    @(posedge clk);
    #1;
    check("reset stall", {31'd0, bus.stall}, 32'd0);
    check("reset valM", bus.valM, 32'd0);
    check("reset dmem_error", {31'd0, bus.dmem_error}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Aligned write, then read back.
    do_op("wr010", 1'b0, 1'b1, 32'h010, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    do_op("rd010", 1'b1, 1'b0, 32'h010, 32'h0, 1'b0, 32'h1122_3344, 1'b0);

    // Highest valid word, then out-of-range and wrapping requests that must not touch it.
    do_op("wrFFC", 1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    do_op("rdFFC", 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);
    do_op("rd1000", 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b0);
    do_op("wrFFD", 1'b0, 1'b1, 32'hFFD, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    do_op("rdFFC_again", 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Conflicting read+write request.
    do_op("wr020", 1'b0, 1'b1, 32'h020, 32'h0102_0304, 1'b0, 32'h0, 1'b0);
    do_op("rdwr020", 1'b1, 1'b1, 32'h020, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    do_op("rd020", 1'b1, 1'b0, 32'h020, 32'h0, 1'b0, 32'h0102_0304, 1'b0);

    // Unaligned access at 0x021.
`ifdef DMEM_ALIGN_CHECK_EN
    do_op("wr021", 1'b0, 1'b1, 32'h021, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    do_op("rd021", 1'b1, 1'b0, 32'h021, 32'h0, 1'b1, 32'h0, 1'b0);
    do_op("rd020_unchanged", 1'b1, 1'b0, 32'h020, 32'h0, 1'b0, 32'h0102_0304, 1'b0);
`else
    do_op("wr021", 1'b0, 1'b1, 32'h021, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    do_op("rd021", 1'b1, 1'b0, 32'h021, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_op("rd020_merged", 1'b1, 1'b0, 32'h020, 32'h0, 1'b0, 32'hADBE_EF04, 1'b0);
`endif

    // Reset during a write, after the first two bytes have been stored.
    do_op("wr040", 1'b0, 1'b1, 32'h040, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h040;
    bus.mem_data  = 32'h5566_7788;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("midrst stall_in_xfer", {31'd0, bus.stall}, 32'd1);
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    #1;
    check("midrst stall", {31'd0, bus.stall}, 32'd0);
    check("midrst valM", bus.valM, 32'd0);
    check("midrst dmem_error", {31'd0, bus.dmem_error}, 32'd0);
    valm_model = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst stall", {31'd0, bus.stall}, 32'd0);
    do_op("rd040", 1'b1, 1'b0, 32'h040, 32'h0, 1'b0, 32'hAAAA_7788, 1'b0);

    // Back-to-back reads: the request is held through DONE, and the next one is issued in the following IDLE cycle.
    do_op("b2b_rd010", 1'b1, 1'b0, 32'h010, 32'h0, 1'b0, 32'h1122_3344, 1'b1);
    do_op("b2b_rd040", 1'b1, 1'b0, 32'h040, 32'h0, 1'b0, 32'hAAAA_7788, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
